// File: rtl/alarm_state_ctrl.sv
// alarm_state_ctrl: conditions the six raw switches (sync + debounce), runs the
// arm / entry-delay / alarm state machine, keeps sticky alarm flags and
// publishes a frame-aligned 2-bit alarm code for the colour generator.
// Optional blinking of the published code is enabled by defining ALARM_BLINK_EN.
// state_o exposes the FSM state for debug: 0 DISARMED, 1 ARMED, 2 ENTRY, 3 ALARM.
module alarm_state_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ENTRY_FRAMES    = 300,
  parameter int BLINK_FRAMES    = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sw_raw,
  input  logic       frame_start,
  output logic [1:0] alarm_code,
  output logic       armed_o,
  output logic       entry_pending,
  output logic       clear_active,
  output logic [1:0] state_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int ENT_W = $clog2(ENTRY_FRAMES + 1);
  localparam logic [ENT_W-1:0] ENT_LAST = ENT_W'(ENTRY_FRAMES - 1);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_ENTRY    = 2'd2,
    S_ALARM    = 2'd3
  } state_t;

  logic [5:0]       sync1_q, sync2_q;
  logic [5:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];

  state_t           state_q, state_d;
  logic [ENT_W-1:0] ent_q, ent_d;
  logic             intr_set;

  logic             temp_q, temp_d, win_q, win_d, intr_q, intr_d;
  logic [1:0]       code_q, code_d, prio_code;
  logic             blank_code;
  logic             armed_q, pend_q, clr_q;

  logic d_armed, d_door, d_window, d_clear, d_motion, d_temp;
  assign d_armed  = deb_q[0];
  assign d_door   = deb_q[1];
  assign d_window = deb_q[2];
  assign d_clear  = deb_q[3];
  assign d_motion = deb_q[4];
  assign d_temp   = deb_q[5];

  // Per-bit debounce: count consecutive disagreeing clocks, flip on the last one.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) deb_d[i] = ~deb_q[i];
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Two-flop synchroniser and debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Next-state logic; clear overrides everything, disarm beats entry expiry.
  always_comb begin
    state_d  = state_q;
    ent_d    = ent_q;
    intr_set = 1'b0;
    if (d_clear) begin
      state_d = S_DISARMED;
      ent_d   = '0;
    end else begin
      case (state_q)
        S_DISARMED: if (d_armed) state_d = S_ARMED;
        S_ARMED: begin
          if (!d_armed) begin
            state_d = S_DISARMED;
          end else if (d_door && d_motion) begin
            state_d = S_ENTRY;
            ent_d   = '0;
          end
        end
        S_ENTRY: begin
          if (!d_armed) begin
            state_d = S_DISARMED;
            ent_d   = '0;
          end else if (frame_start) begin
            if (ent_q == ENT_LAST) begin
              state_d  = S_ALARM;
              ent_d    = '0;
              intr_set = 1'b1;
            end else begin
              ent_d = ent_q + ENT_W'(1);
            end
          end
        end
        S_ALARM: state_d = S_ALARM;
        default: state_d = S_DISARMED;
      endcase
    end
  end

  // Sticky flags: set by their condition, wiped while clear is held.
  always_comb begin
    temp_d = d_clear ? 1'b0 : (temp_q | d_temp);
    win_d  = d_clear ? 1'b0 : (win_q | d_window);
    intr_d = d_clear ? 1'b0 : (intr_q | intr_set);
  end

  // Priority encode of the flags into the published code.
  always_comb begin
    if (temp_q)      prio_code = 2'd3;
    else if (win_q)  prio_code = 2'd2;
    else if (intr_q) prio_code = 2'd1;
    else             prio_code = 2'd0;
  end

`ifdef ALARM_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  logic             any_flag, phase_q, phase_d;
  logic [BLK_W-1:0] bcnt_q, bcnt_d;
  assign any_flag   = temp_q | win_q | intr_q;
  assign blank_code = any_flag && !phase_q;

  // Blink phase: restarts high when idle so a new alarm shows colour first.
  always_comb begin
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    if (!any_flag) begin
      phase_d = 1'b1;
      bcnt_d  = '0;
    end else if (frame_start) begin
      if (bcnt_q == BLK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BLK_W'(1);
      end
    end
  end

  // Blink registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
    end
  end
`else
  logic blink_unused;
  assign blink_unused = (BLINK_FRAMES > 0);
  assign blank_code   = 1'b0;
`endif

  // Code only moves on frame_start, except clear which blanks at once.
  always_comb begin
    code_d = code_q;
    if (d_clear)          code_d = 2'd0;
    else if (frame_start) code_d = blank_code ? 2'd0 : prio_code;
  end

  // FSM, flag, code and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DISARMED;
      ent_q   <= '0;
      temp_q  <= 1'b0;
      win_q   <= 1'b0;
      intr_q  <= 1'b0;
      code_q  <= 2'd0;
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      temp_q  <= temp_d;
      win_q   <= win_d;
      intr_q  <= intr_d;
      code_q  <= code_d;
      armed_q <= d_armed;
      pend_q  <= (state_q == S_ENTRY);
      clr_q   <= d_clear;
    end
  end

  assign alarm_code    = code_q;
  assign armed_o       = armed_q;
  assign entry_pending = pend_q;
  assign clear_active  = clr_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_alarm_state_ctrl.sv
// Testbench for alarm_state_ctrl: directed scenarios plus random switch
// activity, compared every clock against a rule-level reference model.
module tb_alarm_state_ctrl;

  localparam int DB = 4;
  localparam int EF = 3;
  localparam int BF = 2;
  localparam int FP = 20;

  localparam logic [5:0] K_ARM  = 6'b000001;
  localparam logic [5:0] K_DOOR = 6'b000010;
  localparam logic [5:0] K_WIN  = 6'b000100;
  localparam logic [5:0] K_CLR  = 6'b001000;
  localparam logic [5:0] K_MOT  = 6'b010000;
  localparam logic [5:0] K_TEMP = 6'b100000;

  localparam int MD_OFF   = 0;
  localparam int MD_SET   = 1;
  localparam int MD_WAIT  = 2;
  localparam int MD_ALARM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sw_raw = '0;
  logic       frame_start = 1'b0;
  logic [1:0] alarm_code;
  logic       armed_o, entry_pending, clear_active;
  logic [1:0] state_o;

  int n_chk = 0;
  int n_fail = 0;
  int fr_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  alarm_state_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .ENTRY_FRAMES   (EF),
    .BLINK_FRAMES   (BF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_raw       (sw_raw),
    .frame_start  (frame_start),
    .alarm_code   (alarm_code),
    .armed_o      (armed_o),
    .entry_pending(entry_pending),
    .clear_active (clear_active),
    .state_o      (state_o)
  );

  // ---------------- reference model ----------------
  // Debounced bit flips once the last DB synchronised samples (raw delayed by
  // two clocks) all disagree with it; the rest follows the behavioural rules.
  logic [5:0] raw_hist [0:DB];
  logic [5:0] m_deb;
  logic       m_temp, m_win, m_intr, m_phase;
  int         m_mode, m_frames, m_bcnt;
  logic [1:0] m_code;
  logic       m_armed_o, m_pend, m_clr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DB; i++) raw_hist[i] <= '0;
      m_deb <= '0; m_temp <= 1'b0; m_win <= 1'b0; m_intr <= 1'b0;
      m_mode <= MD_OFF; m_frames <= 0; m_code <= 2'd0;
      m_armed_o <= 1'b0; m_pend <= 1'b0; m_clr <= 1'b0;
      m_phase <= 1'b0; m_bcnt <= 0;
    end else begin : step
      logic [5:0] nd;
      logic all_diff, t, w, it, ph, any, cl;
      logic [1:0] cd, pc;
      int md, fr, bc;
      nd = m_deb;
      for (int b = 0; b < 6; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DB; k++) if (raw_hist[k][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) nd[b] = ~m_deb[b];
      end
      cl = m_deb[3];
      t = m_temp; w = m_win; it = m_intr; md = m_mode; fr = m_frames;
      cd = m_code; ph = m_phase; bc = m_bcnt;
      any = m_temp | m_win | m_intr;
      if (frame_start) begin
        pc = m_temp ? 2'd3 : m_win ? 2'd2 : m_intr ? 2'd1 : 2'd0;
`ifdef ALARM_BLINK_EN
        if (!m_phase && any) pc = 2'd0;
`endif
        cd = pc;
      end
`ifdef ALARM_BLINK_EN
      if (!any) begin
        ph = 1'b1; bc = 0;
      end else if (frame_start) begin
        bc = m_bcnt + 1;
        if (bc == BF) begin bc = 0; ph = ~m_phase; end
      end
`endif
      if (cl) begin
        cd = 2'd0; t = 1'b0; w = 1'b0; it = 1'b0; md = MD_OFF; fr = 0;
      end else begin
        t = t | m_deb[5];
        w = w | m_deb[2];
        if (m_mode == MD_OFF) begin
          if (m_deb[0]) md = MD_SET;
        end else if (m_mode == MD_SET) begin
          if (!m_deb[0]) md = MD_OFF;
          else if (m_deb[1] && m_deb[4]) begin md = MD_WAIT; fr = 0; end
        end else if (m_mode == MD_WAIT) begin
          if (!m_deb[0]) md = MD_OFF;
          else if (frame_start) begin
            fr = m_frames + 1;
            if (fr == EF) begin md = MD_ALARM; it = 1'b1; end
          end
        end
      end
      raw_hist[0] <= sw_raw;
      for (int i = 1; i <= DB; i++) raw_hist[i] <= raw_hist[i-1];
      m_deb <= nd; m_temp <= t; m_win <= w; m_intr <= it;
      m_mode <= md; m_frames <= fr; m_code <= cd; m_phase <= ph; m_bcnt <= bc;
      m_armed_o <= m_deb[0];
      m_pend <= (m_mode == MD_WAIT);
      m_clr <= m_deb[3];
    end
  end

  function automatic logic [4:0] dut_vec();
    return {alarm_code, armed_o, entry_pending, clear_active};
  endfunction

  function automatic logic [4:0] mdl_vec();
    return {m_code, m_armed_o, m_pend, m_clr};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    frame_start = (fr_cnt == FP - 1);
    fr_cnt = (fr_cnt == FP - 1) ? 0 : fr_cnt + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Next posedge after this is edge 1 of a frame; frame_start lands on edges 20, 40, ...
  task automatic align();
    while (fr_cnt != 0) cycle();
  endtask

  task automatic cleanup();
    sw_raw = K_CLR;
    repeat (8) cycle();
    sw_raw = '0;
    repeat (12) cycle();
    align();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_chk++;
    if (dut_vec() !== 5'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 5'd0);
    end
    n_chk++;
    if (state_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o);
    end
    rst_n = 1'b1;
    repeat (3) begin
      cycle();
      n_chk++;
      if (dut_vec() !== 5'd0) begin
        n_fail++; $display("FAIL reset_idle got=%b exp=%b", dut_vec(), 5'd0);
      end
    end
    align();
  endtask

  task automatic test_debounce();
    logic [5:0] pats [4] = '{K_TEMP, 6'd0, K_TEMP, 6'd0};
    int holds [4] = '{3, 37, 10, 30};
    for (int p = 0; p < 4; p++) begin
      sw_raw = pats[p];
      for (int i = 0; i < holds[p]; i++) begin
        cycle();
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++; $display("FAIL debounce_trace t=%0t got=%b exp=%b", $time, dut_vec(), mdl_vec());
        end
      end
      if (p == 1) begin
        n_chk++;
        if (alarm_code !== 2'd0) begin
          n_fail++; $display("FAIL glitch_code got=%0d exp=0", alarm_code);
        end
      end
      if (p == 3) begin
        n_chk++;
        if (alarm_code !== 2'd3) begin
          n_fail++; $display("FAIL temp_sticky got=%0d exp=3", alarm_code);
        end
      end
    end
    cleanup();
  endtask

  task automatic test_priority();
    logic [5:0] pats [5] = '{K_WIN, K_WIN | K_TEMP, K_WIN, K_WIN | K_CLR, K_WIN};
    int holds [5] = '{3, 22, 10, 8, 28};
    for (int p = 0; p < 5; p++) begin
      sw_raw = pats[p];
      for (int i = 0; i < holds[p]; i++) begin
        cycle();
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++; $display("FAIL priority_trace t=%0t got=%b exp=%b", $time, dut_vec(), mdl_vec());
        end
      end
      if (p == 1) begin
        n_chk++;
        if (alarm_code !== 2'd3) begin
          n_fail++; $display("FAIL temp_over_window got=%0d exp=3", alarm_code);
        end
      end
      if (p == 3) begin
        n_chk++;
        if ({alarm_code, clear_active} !== 3'b001) begin
          n_fail++; $display("FAIL clear_blanks got=%b exp=001", {alarm_code, clear_active});
        end
      end
      if (p == 4) begin
        n_chk++;
        if (alarm_code !== 2'd2) begin
          n_fail++; $display("FAIL window_after_clear got=%0d exp=2", alarm_code);
        end
      end
    end
    cleanup();
  endtask

  task automatic test_intrusion();
    logic [5:0] pats [4] = '{K_ARM, K_ARM | K_DOOR | K_MOT, K_ARM | K_DOOR | K_MOT, 6'd0};
    int holds [4] = '{10, 10, 65, 20};
    for (int p = 0; p < 4; p++) begin
      sw_raw = pats[p];
      for (int i = 0; i < holds[p]; i++) begin
        cycle();
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++; $display("FAIL intrusion_trace t=%0t got=%b exp=%b", $time, dut_vec(), mdl_vec());
        end
      end
      if (p == 1) begin
        n_chk++;
        if (entry_pending !== 1'b1) begin
          n_fail++; $display("FAIL entry_pending got=%b exp=1", entry_pending);
        end
      end
      if (p >= 2) begin
        n_chk++;
        if ({state_o, alarm_code} !== {2'd3, 2'd1}) begin
          n_fail++; $display("FAIL intrusion_alarm p=%0d got state=%0d code=%0d exp state=3 code=1", p, state_o, alarm_code);
        end
      end
    end
    cleanup();
  endtask

  task automatic test_abort();
    logic [5:0] pats [4] = '{K_ARM, K_ARM | K_DOOR | K_MOT, K_DOOR | K_MOT, 6'd0};
    int holds [4] = '{10, 20, 10, 40};
    for (int p = 0; p < 4; p++) begin
      sw_raw = pats[p];
      for (int i = 0; i < holds[p]; i++) begin
        cycle();
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++; $display("FAIL abort_trace t=%0t got=%b exp=%b", $time, dut_vec(), mdl_vec());
        end
      end
    end
    n_chk++;
    if ({state_o, alarm_code, entry_pending} !== 5'b00000) begin
      n_fail++; $display("FAIL abort_disarmed got state=%0d code=%0d pend=%b exp 0 0 0", state_o, alarm_code, entry_pending);
    end
    cleanup();
  endtask

  task automatic test_reset_mid();
    sw_raw = K_ARM | K_DOOR | K_MOT;
    repeat (25) cycle();
    n_chk++;
    if (entry_pending !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_entry got=%b exp=1", entry_pending);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({dut_vec(), state_o} !== 7'd0) begin
      n_fail++; $display("FAIL async_reset got=%b exp=%b", {dut_vec(), state_o}, 7'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cycle();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL post_reset_trace t=%0t got=%b exp=%b", $time, dut_vec(), mdl_vec());
      end
      if (i == 2) begin
        n_chk++;
        if (armed_o !== 1'b0) begin
          n_fail++; $display("FAIL rearm_debounce got=%b exp=0", armed_o);
        end
      end
    end
    n_chk++;
    if (armed_o !== 1'b1) begin
      n_fail++; $display("FAIL rearm_done got=%b exp=1", armed_o);
    end
    cleanup();
  endtask

  task automatic test_blink();
    logic [1:0] got_q [$];
    logic [1:0] exp_q [$];
`ifdef ALARM_BLINK_EN
    exp_q = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2};
`else
    exp_q = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
    sw_raw = K_WIN;
    for (int i = 0; i < 125; i++) begin
      cycle();
      if (frame_start && got_q.size() < 6) got_q.push_back(alarm_code);
    end
    n_chk++;
    if (got_q.size() != 6) begin
      n_fail++; $display("FAIL blink_count got=%0d exp=6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL blink_frame%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]);
      end
    end
    cleanup();
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 120; seg++) begin
      int hold;
      logic [5:0] r;
      hold = $urandom_range(1, 30);
      r = '0;
      r[0] = ($urandom_range(0, 9) != 0);
      r[1] = $urandom_range(0, 1);
      r[2] = ($urandom_range(0, 5) == 0);
      r[3] = ($urandom_range(0, 12) == 0);
      r[4] = $urandom_range(0, 1);
      r[5] = ($urandom_range(0, 7) == 0);
      sw_raw = r;
      for (int i = 0; i < hold; i++) begin
        cycle();
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++; $display("FAIL random_trace t=%0t raw=%b got=%b exp=%b", $time, sw_raw, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw_raw = '0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_debounce();
    test_priority();
    test_intrusion();
    test_abort();
    test_reset_mid();
    test_blink();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
